// File: rtl/antirebote_fsm.sv
`default_nettype none
// ============================================================================
// Module      : antirebote_fsm
// Description : Four-state button debouncer with press/release pulses and
//               a wrapping count of accepted presses.
// Revision    : 1.0 - initial release
// ============================================================================
module antirebote_fsm #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_sync,
    output logic               btn_clean,
    output logic               btn_rise,
    output logic               btn_fall,
    output logic [COUNT_W-1:0] press_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_clean;
    logic               w_clean_nxt;
    logic               r_rise;
    logic               w_rise_nxt;
    logic               r_fall;
    logic               w_fall_nxt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_count <= w_count_nxt;
        end
    end

    // The first changed sample enters WAIT_*; STABLE_CYCLES more confirm it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_count_nxt = r_count;
        case (r_state)
            IDLE_LOW: begin
                w_cnt_nxt = '0;
                if (btn_sync) begin
                    w_state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (!btn_sync) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_clean_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_count_nxt = r_count + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                w_cnt_nxt = '0;
                if (!btn_sync) begin
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (btn_sync) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_clean_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_clean   = r_clean;
    assign btn_rise    = r_rise;
    assign btn_fall    = r_fall;
    assign press_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_antirebote_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_antirebote_fsm
// Description : Directed, scoreboard-checked bench for antirebote_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_antirebote_fsm;

    localparam int STABLE_CYCLES = 4;
    localparam int COUNT_W       = 8;

    logic               clk;
    logic               rst;
    logic               btn_sync;
    logic               btn_clean;
    logic               btn_rise;
    logic               btn_fall;
    logic [COUNT_W-1:0] press_count;

    antirebote_fsm #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .COUNT_W      (COUNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn_sync   (btn_sync),
        .btn_clean  (btn_clean),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               clean;
        logic               rise;
        logic               fall;
        logic [COUNT_W-1:0] count;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   m_run;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference: count consecutive samples differing from the clean level.
    task automatic model_reset();
        m.clean = 1'b0;
        m.rise  = 1'b0;
        m.fall  = 1'b0;
        m.count = '0;
        m_run   = 0;
    endtask

    task automatic model_sample(input logic b);
        m.rise = 1'b0;
        m.fall = 1'b0;
        if (b != m.clean) begin
            m_run++;
            if (m_run == STABLE_CYCLES + 1) begin
                m.clean = b;
                m_run   = 0;
                if (b) begin
                    m.rise  = 1'b1;
                    m.count = m.count + 1'b1;
                end else begin
                    m.fall = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_clean"}, 32'(btn_clean), 32'(e.clean));
            chk({tag, "_rise"},  32'(btn_rise),  32'(e.rise));
            chk({tag, "_fall"},  32'(btn_fall),  32'(e.fall));
            chk({tag, "_count"}, 32'(press_count), 32'(e.count));
        end
    endtask

    task automatic step(input logic b, input string tag);
        btn_sync = b;
        model_sample(b);
        sb.push_back(m);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic reset_cycle(input string tag);
        @(posedge clk);
        #1;
        sb.push_back(m);
        compare_out(tag);
    endtask

    task automatic press_release();
        for (int i = 0; i < STABLE_CYCLES + 1; i++) step(1'b1, "pair_hi");
        for (int i = 0; i < STABLE_CYCLES + 1; i++) step(1'b0, "pair_lo");
    endtask

    initial begin
        rst      = 1'b0;
        btn_sync = 1'b0;
        model_reset();

        // Reset held three cycles, then idle low.
        for (int i = 0; i < 3; i++) reset_cycle("reset");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, "idle_low");

        // Clean press: accepted on the fifth sampling edge.
        for (int i = 0; i < 10; i++) step(1'b1, $sformatf("press%0d", i + 1));
        chk("press_count_after_press", 32'(press_count), 32'd1);

        // Clean release: fall on the fifth edge.
        for (int i = 0; i < 6; i++) step(1'b0, $sformatf("release%0d", i + 1));
        chk("clean_after_release", 32'(btn_clean), 32'd0);

        // Bounce never reaching acceptance.
        for (int r = 0; r < 4; r++) begin
            step(1'b1, "bounce");
            step(1'b1, "bounce");
            step(1'b1, "bounce");
            step(1'b0, "bounce");
        end
        chk("count_after_bounce", 32'(press_count), 32'd1);

        // Fresh reset, then 255 pairs and one wrapping pair.
        #3 rst = 1'b0;
        model_reset();
        #1;
        sb.push_back(m);
        compare_out("async_reset1");
        reset_cycle("reset1_hold");
        rst = 1'b1;
        for (int p = 0; p < 255; p++) press_release();
        chk("count_255", 32'(press_count), 32'd255);
        for (int i = 0; i < STABLE_CYCLES + 1; i++) step(1'b1, "wrap_hi");
        chk("count_wrap", 32'(press_count), 32'd0);
        for (int i = 0; i < STABLE_CYCLES + 1; i++) step(1'b0, "wrap_lo");

        // Async reset in the middle of WAIT_HIGH discards the partial count.
        for (int i = 0; i < 3; i++) step(1'b1, "pre_reset");
        #3 rst = 1'b0;
        model_reset();
        #1;
        sb.push_back(m);
        compare_out("async_reset2");
        for (int i = 0; i < 2; i++) reset_cycle("reset2_hold");
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, $sformatf("post_reset%0d", i + 1));
        chk("post_reset_count", 32'(press_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/antirebote_fsm.md
ANTIREBOTE_FSM -- requirements
Module: antirebote_fsm

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000, meaning the consecutive stable samples required after the first changed sample; legal range 2..2^24.
REQ-002 SHALL have parameter COUNT_W, default 8, meaning the width of press_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn_sync, input, 1, button level already synchronized to clk by the upstream two-flop synchronizer.
REQ-006 SHALL have port btn_clean, output, 1, debounced button level.
REQ-007 SHALL have port btn_rise, output, 1, one-cycle pulse on accepted press.
REQ-008 SHALL have port btn_fall, output, 1, one-cycle pulse on accepted release.
REQ-009 SHALL have port press_count, output, COUNT_W, count of accepted presses.

Function
REQ-010 SHALL implement a four-state FSM: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 SHALL hold a stability counter cnt of width $clog2(STABLE_CYCLES), no wider.
REQ-012 IDLE_LOW: btn_sync=1 -> WAIT_HIGH with cnt=0; otherwise stay.
REQ-013 WAIT_HIGH: btn_sync=0 -> IDLE_LOW, cnt=0, no pulse (bounce rejected).
REQ-014 WAIT_HIGH: btn_sync=1 and cnt<STABLE_CYCLES-1 -> stay, cnt+1.
REQ-015 WAIT_HIGH: btn_sync=1 and cnt=STABLE_CYCLES-1 -> IDLE_HIGH; same edge sets btn_clean=1, btn_rise=1, press_count+1.
REQ-016 IDLE_HIGH, WAIT_LOW SHALL mirror REQ-012..015 with btn_sync inverted; acceptance sets btn_clean=0, btn_fall=1, press_count unchanged.
REQ-017 Latency: btn_clean SHALL change on the (STABLE_CYCLES+1)th consecutive rising edge sampling the new level; any opposite sample before that restarts the sequence.
REQ-018 btn_rise and btn_fall SHALL be registered, high exactly one cycle per acceptance, never simultaneously high.
REQ-019 btn_clean SHALL be registered and change only on acceptance edges.
REQ-020 press_count SHALL wrap modulo 2^COUNT_W (all-ones + 1 -> 0) without pausing or flagging.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1; cnt SHALL be 0 in IDLE_LOW and IDLE_HIGH.
REQ-022 Illegal state encodings SHALL transition to IDLE_LOW on the next edge with cnt=0.
REQ-023 All outputs SHALL be glitch-free register outputs; no combinational path from btn_sync to any output.

Reset
REQ-024 rst=0 SHALL immediately, independent of clk, force state=IDLE_LOW, cnt=0, btn_clean=0, btn_rise=0, btn_fall=0, press_count=0.
REQ-025 Reset asserted mid-WAIT_HIGH or mid-WAIT_LOW SHALL discard the partial count; no pulse SHALL be emitted for it.
REQ-026 After rst deassertion with btn_sync=1, a full STABLE_CYCLES+1 stable samples SHALL be required before btn_clean=1.

Verification (STABLE_CYCLES=4, COUNT_W=8)
REQ-027 Reset 3 cycles, release, btn_sync=0 for 20 cycles -> btn_clean=0, btn_rise=0, btn_fall=0, press_count=0 throughout.
REQ-028 btn_sync=1 held 10 cycles -> btn_clean=1 and btn_rise=1 at 5th sampling edge; btn_rise=0 on 6th; press_count=1.
REQ-029 Bounce: pattern 1,1,1,0 repeated 4 times -> btn_clean stays 0, no pulses, press_count=0.
REQ-030 From accepted high, btn_sync=0 held 6 cycles -> btn_clean=0 and btn_fall=1 at 5th edge for one cycle; press_count unchanged.
REQ-031 255 clean press/release pairs -> press_count=255; one more -> press_count=0, btn_rise still pulses.
REQ-032 btn_sync=1, rst=0 asserted asynchronously after 3rd edge, released 2 cycles later with btn_sync=1 -> outputs 0 during reset; btn_clean=1 only on 5th edge after release.
